mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as a responder on the processor core's data-memory port.
- Port signalling matches the data BRAM: word address, 4-bit byte write enables, one-cycle registered read data.
- Top-level address decode routes a data-port region here; the core writes bytes, which are queued in a FIFO and serialized 8N1 on tx.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; must be a power of 2, minimum 2.
- DEFAULT_DIV, 16'd867, reset value of BAUDDIV; bit time = BAUDDIV+1 clk cycles.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- ena  in  1  access select; qualifies we and the rdata update.
- wea  in  4  byte write enables, lane i = bits [8i+7:8i].
- addra  in  2  word offset within the peripheral (byte address bits [3:2]).
- dina  in  32  write data.
- douta  out  32  registered read data.
- tx  out  1  serial output, idle high.

Behaviour:
- Register map, by word offset:
  - 0 TXDATA: a write with wea[0] pushes dina[7:0]; reads return 0.
  - 1 STATUS: read value is {27'b0, ovf, busy, empty, full, 1'b0}. A write with wea[0] and dina[4]=1 clears ovf.
  - 2 BAUDDIV: bits [15:0], byte-lane writable via wea[1:0]; reads return {16'b0, BAUDDIV}.
  - 3: reserved, reads 0, writes ignored (unless UART_TX_IRQ_EN).
- Reset values: douta=0, tx=1, FIFO empty, ovf=0, BAUDDIV=DEFAULT_DIV, FSM=IDLE, baud counter=0, bit index=0.
- Reset asserted mid-frame: tx returns high immediately (async reset); all queued bytes are discarded.
- Read timing: on a clk edge with ena=1, douta <= value of register at addra, sampled before that edge's writes take effect (read-first). With ena=0, douta holds. wea does not suppress the read update.
- Writes take effect only when ena=1; wea=0 with ena=1 is a pure read.
- FIFO:
  - Push when ena & wea[0] & addra==0.
  - Push while full: byte dropped, ovf set (sticky).
  - Pop when the FSM leaves IDLE.
  - Simultaneous push and pop on a full FIFO: the pop frees a slot, so the push is accepted and ovf is not set.
  - Pointers wrap modulo FIFO_DEPTH; an occupancy counter of width log2(FIFO_DEPTH)+1 drives full/empty.
- FSM:
  - States: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If !empty, pop into the shift register, load baud counter with BAUDDIV, go to START.
  - START: tx=0 for one bit time.
  - DATA: shift out LSB first, 8 bits, bit index 0..7.
  - STOP: tx=1 for one bit time, then IDLE. Back-to-back bytes leave no extra idle cycle beyond the single IDLE evaluation cycle.
  - Bit time: the counter decrements each clk and the bit ends when the counter reaches 0, so each bit lasts BAUDDIV+1 cycles. The counter reloads from the current BAUDDIV at every bit boundary, so a BAUDDIV write mid-frame takes effect at the next bit.
  - BAUDDIV=0: one cycle per bit; must work.
- busy = FSM != IDLE.
- The first start-bit cycle is the 2nd clk edge after the push edge (push, then IDLE pop, then START).

Optional Feature:
- Macro UART_TX_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit).
  - Word offset 3 becomes CTRL: bit0 ie, reset 0, writable via wea[0]; reads return {31'b0, ie}.
  - irq is registered: irq <= ie & empty & ~busy. It is level-sensitive, cleared by a push or by ie=0; reset value 0.
- When undefined: no irq port; offset 3 is reserved, as above.

Test Plan:
- Reset, then read offsets 1 and 2 -> douta = 32'h0000_0004 (empty) and 32'h0000_0363 one cycle after each read.
- BAUDDIV=3, write 0xA5 to TXDATA -> tx shows start 0, bits 1,0,1,0,0,1,0,1, stop 1; each bit exactly 4 cycles; busy=1 throughout, then STATUS=0x4.
- BAUDDIV=0, push FIFO_DEPTH+2 bytes back-to-back while the first transmits -> exactly FIFO_DEPTH+1 bytes serialized (one popped early), ovf=1. Then write STATUS dina=0x10 -> ovf=0.
- Write BAUDDIV with wea=4'b0001, dina=0x12 -> BAUDDIV=0x0312. Then write during DATA -> the new bit length applies from the next bit boundary only.
- Assert reset in the middle of a DATA bit -> tx=1 in the same cycle without waiting for clk. After release, STATUS=0x4 and no residual bytes are sent.
- With UART_TX_IRQ_EN: set ie=1 while idle and empty -> irq=1 next cycle. Push a byte -> irq=0 the cycle after. irq=1 again one cycle after STOP completes.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO behind a BRAM-style data port.
// Define UART_TX_IRQ_EN to add the CTRL register at offset 3 and the level-sensitive irq output.
module mmio_uart_tx #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  input  logic [3:0]  wea,
  input  logic [1:0]  addra,
  input  logic [31:0] dina,
  output logic [31:0] douta,
`ifdef UART_TX_IRQ_EN
  output logic        irq,
`endif
  output logic        tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_next;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, busy, ovf;
  logic [15:0]   baud_div, baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          push_req, push_ok, pop, ovf_clr;
  logic          bit_end, load_cnt, shift_en, tx_next;
  logic [31:0]   rdata;
  logic          unused_bits;

  assign unused_bits = ^{wea[3:2], dina[31:16]};

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign push_req = ena && wea[0] && (addra == 2'd0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_clr  = ena && wea[0] && (addra == 2'd1) && dina[4];
  assign bit_end  = (baud_cnt == 16'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (push_req && full && !pop) ovf <= 1'b1;
      else if (ovf_clr)             ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= dina[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) baud_div <= DEFAULT_DIV;
    else if (ena && (addra == 2'd2)) begin
      if (wea[0]) baud_div[7:0]  <= dina[7:0];
      if (wea[1]) baud_div[15:8] <= dina[15:8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_cnt   = 1'b0;
    shift_en   = 1'b0;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          load_cnt   = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_end) begin
          load_cnt   = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        tx_next = shreg[0];
        if (bit_end) begin
          load_cnt = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The counter reloads from the live divider at each bit boundary, so divider writes apply from the next bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      tx       <= 1'b1;
    end else begin
      tx <= tx_next;
      if (load_cnt)     baud_cnt <= baud_div;
      else if (!bit_end) baud_cnt <= baud_cnt - 1'b1;
      if (pop)           bit_idx <= 3'd0;
      else if (shift_en) bit_idx <= bit_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop)           shreg <= mem[rd_ptr];
    else if (shift_en) shreg <= {1'b0, shreg[7:1]};
  end

`ifdef UART_TX_IRQ_EN
  logic ie;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (ena && wea[0] && (addra == 2'd3)) ie <= dina[0];
      irq <= ie & empty & ~busy;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (addra)
      2'd1:    rdata = {27'b0, ovf, busy, empty, full, 1'b0};
      2'd2:    rdata = {16'b0, baud_div};
`ifdef UART_TX_IRQ_EN
      2'd3:    rdata = {31'b0, ie};
`endif
      default: rdata = '0;
    endcase
  end

  // Read-first: douta captures register values as they were before this edge's writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    douta <= 32'd0;
    else if (ena) douta <= rdata;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: register reads and received UART bytes are checked by monitors.
module tb_mmio_uart_tx;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        ena;
  logic [3:0]  wea;
  logic [1:0]  addra;
  logic [31:0] dina;
  logic [31:0] douta;
  logic        tx;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd867)) dut (
    .clk   (clk),
    .reset (reset),
    .ena   (ena),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta),
`ifdef UART_TX_IRQ_EN
    .irq   (irq),
`endif
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] v;
  } rd_t;

  rd_t        rd_q[$];
  logic [7:0] tx_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         ecount  = 0;
  logic       txlog [0:4095];
  logic       rd_req;
  logic       rd_vld = 1'b0;
  logic       rx_en;
  int         rx_bits;
  int         rb;
  logic [7:0] rv;
  logic       rstp;
  logic [7:0] rexp;
  rd_t        re;
  int         p, q, mism, idx, len;
  logic [9:0] fr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) ecount <= ecount + 1;

  always @(negedge clk) begin
    if (ecount < 4096) txlog[ecount] = tx;
  end

  always @(posedge clk) rd_vld <= ena && rd_req;

  // Read monitor: douta is due one edge after a read was issued.
  always @(negedge clk) begin
    if (rd_vld) begin
      if (rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got %h, expected no read", douta);
      end else begin
        re = rd_q.pop_front();
        check(re.nm, douta, re.v);
      end
    end
  end

  // Serial monitor: samples mid-bit at rx_bits cycles per bit.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_en && tx === 1'b0) begin
        rb = rx_bits;
        repeat (rb / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (rb) @(negedge clk);
          rv[i] = tx;
        end
        repeat (rb) @(negedge clk);
        rstp = tx;
        if (tx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_extra_byte: got %h, expected none", rv);
        end else begin
          rexp = tx_q.pop_front();
          check("rx_byte", {24'b0, rv}, {24'b0, rexp});
          check("rx_stop", {31'b0, rstp}, 32'd1);
        end
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] w);
    ena = 1'b1; wea = w; addra = a; dina = d;
    @(negedge clk);
    ena = 1'b0; wea = 4'b0;
  endtask

  task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
    rd_q.push_back('{nm, exp});
    ena = 1'b1; wea = 4'b0; addra = a; rd_req = 1'b1;
    @(negedge clk);
    ena = 1'b0; rd_req = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input bit expect_sent);
    if (expect_sent) tx_q.push_back(b);
    wr(2'd0, {24'b0, b}, 4'b0001);
  endtask

  initial begin
    reset = 1'b1; ena = 1'b0; wea = 4'b0; addra = 2'd0; dina = 32'd0;
    rd_req = 1'b0; rx_en = 1'b0; rx_bits = 1;
    @(negedge clk); @(negedge clk);
    check("rst_douta", douta, 32'd0);
    check("rst_tx", {31'b0, tx}, 32'd1);
    reset = 1'b0;

    rd("status_rst", 2'd1, 32'h0000_0004);
    rd("baud_rst", 2'd2, 32'h0000_0363);
    rd("txdata_rd", 2'd0, 32'h0);
    rd("off3_rst", 2'd3, 32'h0);

    wr(2'd2, 32'h0000_0012, 4'b0001);
    rd("baud_lane0", 2'd2, 32'h0000_0312);
    addra = 2'd1; @(negedge clk);
    check("douta_hold", douta, 32'h0000_0312);
    wea = 4'b0011; addra = 2'd2; dina = 32'h5; @(negedge clk); wea = 4'b0;
    rd("baud_ena0_ignored", 2'd2, 32'h0000_0312);

    // 0xA5 at 4 cycles per bit
    wr(2'd2, 32'h3, 4'b0011);
    check("read_first", douta, 32'h0000_0312);
    rx_bits = 4; rx_en = 1'b1;
    push(8'hA5, 1'b1);
    p = ecount;
    repeat (10) @(negedge clk);
    rd("status_busy", 2'd1, 32'h0000_000C);
    repeat (40) @(negedge clk);
    fr = {1'b1, 8'hA5, 1'b0};
    mism = 0;
    if (txlog[p+1] !== 1'b1) mism++;
    for (int j = 0; j < 10; j++)
      for (int r = 0; r < 4; r++)
        if (txlog[p+2+4*j+r] !== fr[j]) mism++;
    if (txlog[p+42] !== 1'b1) mism++;
    check("a5_wave", mism, 32'd0);
    rd("status_done", 2'd1, 32'h0000_0004);

    // Overflow at one cycle per bit
    wr(2'd2, 32'h0, 4'b0011);
    rx_bits = 1;
    for (int i = 0; i < DEPTH + 2; i++) push(8'(16 + i), i <= DEPTH);
    rd("status_ovf", 2'd1, 32'h0000_001A);
    repeat (70) @(negedge clk);
    rd("status_ovf_sticky", 2'd1, 32'h0000_0014);
    wr(2'd1, 32'h10, 4'b0001);
    rd("status_ovf_clr", 2'd1, 32'h0000_0004);

    // Divider change mid-frame: 2-cycle bits until the boundary after the write, then 4
    rx_en = 1'b0;
    wr(2'd2, 32'h1, 4'b0011);
    push(8'h55, 1'b0);
    p = ecount;
    repeat (5) @(negedge clk);
    wr(2'd2, 32'h3, 4'b0011);
    repeat (40) @(negedge clk);
    fr = {1'b1, 8'h55, 1'b0};
    mism = 0;
    idx = p + 2;
    if (txlog[p+1] !== 1'b1) mism++;
    for (int j = 0; j < 10; j++) begin
      len = (j < 3) ? 2 : 4;
      for (int r = 0; r < len; r++) begin
        if (txlog[idx] !== fr[j]) mism++;
        idx++;
      end
    end
    if (txlog[idx] !== 1'b1) mism++;
    check("baud_midframe_wave", mism, 32'd0);

    // Reset in the middle of a data bit
    push(8'h00, 1'b0);
    push(8'h33, 1'b0);
    repeat (7) @(negedge clk);
    check("rst_pre_tx", {31'b0, tx}, 32'd0);
    #2 reset = 1'b1;
    #1 check("rst_async_tx", {31'b0, tx}, 32'd1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    q = ecount;
    rd("status_after_rst", 2'd1, 32'h0000_0004);
    rd("baud_after_rst", 2'd2, 32'h0000_0363);
    repeat (60) @(negedge clk);
    mism = 0;
    for (int k = q; k < ecount; k++) if (txlog[k] !== 1'b1) mism++;
    check("no_residual_tx", mism, 32'd0);

`ifdef UART_TX_IRQ_EN
    check("irq_off", {31'b0, irq}, 32'd0);
    wr(2'd3, 32'h1, 4'b0001);
    @(negedge clk);
    check("irq_set", {31'b0, irq}, 32'd1);
    rd("ctrl_rd", 2'd3, 32'h1);
    wr(2'd2, 32'h3, 4'b0011);
    rx_bits = 4; rx_en = 1'b1;
    push(8'h5A, 1'b1);
    @(negedge clk);
    check("irq_clr_push", {31'b0, irq}, 32'd0);
    repeat (40) @(negedge clk);
    check("irq_low_stop", {31'b0, irq}, 32'd0);
    @(negedge clk);
    check("irq_after_stop", {31'b0, irq}, 32'd1);
`endif

    repeat (20) @(negedge clk);
    check("tx_q_drained", tx_q.size(), 32'd0);
    check("rd_q_drained", rd_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
